dac_tx_sched: RTL and testbench

Transmit scheduler in the `dac_clk` domain. It decides when the DAC transmit path starts a probe burst. It arbitrates between three trigger sources: the ADC-synchronous trigger, a software request, and an internal periodic timer. It issues single-cycle `tx_req` pulses to the probe controller and waits for the burst to complete. Between bursts it enforces a programmable hold-off, and it keeps per-source grant and drop statistics for the AXI register bank.

---
 rtl/dac_tx_sched_pkg.sv | 38 +++
 rtl/dac_tx_sched_sat_cnt.sv | 21 ++
 rtl/dac_tx_sched.sv | 160 ++++++++++++++++
 tb/tb_dac_tx_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_tx_sched_pkg.sv
// Shared definitions for the DAC transmit path: probe widths, trigger source
// encodings, scheduler FSM states and small arbitration helpers.
package dac_tx_sched_pkg;

    localparam int PROBE_CH_W  = 4;
    localparam int PROBE_LEN_W = 12;
    localparam int N_SRC       = 3;

    typedef enum logic [1:0] {
        SRC_SYNC = 2'd0,
        SRC_SW   = 2'd1,
        SRC_PER  = 2'd2
    } src_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_ACTIVE     = 3'd3,
        ST_HOLD       = 3'd4
    } state_e;

    // Fixed priority: sync beats sw beats periodic.
    function automatic src_e prio_pick(input logic [N_SRC-1:0] pend);
        if (pend[0]) begin
            return SRC_SYNC;
        end else if (pend[1]) begin
            return SRC_SW;
        end else begin
            return SRC_PER;
        end
    endfunction

    function automatic logic [N_SRC-1:0] src_onehot(input src_e src);
        return N_SRC'(1) << src;
    endfunction

endpackage

// File: rtl/dac_tx_sched_sat_cnt.sv
// Saturating up-counter with synchronous reset and a clear that wins over
// the increment; used for the per-source grant and drop statistics.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dac_tx_sched.sv
// Transmit scheduler: arbitrates sync / sw / periodic triggers into single
// tx_req pulses, tracks the burst, enforces hold-off and keeps statistics.
module dac_tx_sched
    import dac_tx_sched_pkg::*;
#(
    parameter int PER_W  = 24,
    parameter int HOLD_W = 16,
    parameter int TO_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic               dac_clk,
    input  logic               dac_rst,
    input  logic               cfg_en,
    input  logic [2:0]         cfg_src_en,
    input  logic [PER_W-1:0]   cfg_per_min1,
    input  logic [HOLD_W-1:0]  cfg_hold_min1,
    input  logic [TO_W-1:0]    cfg_to_min1,
    input  logic               req_sync,
    input  logic               req_sw,
    input  logic               txing,
    input  logic               clr_stats,
    output logic               tx_req,
    output logic [1:0]         tx_src,
    output logic               busy,
    output logic               err_to,
    output logic [3*CNT_W-1:0] grant_cnt,
    output logic [3*CNT_W-1:0] drop_cnt
);

    logic              req_sync_d;
    logic [PER_W-1:0]  per_cnt;
    logic [N_SRC-1:0]  pend;
    logic [N_SRC-1:0]  ev;
    logic [N_SRC-1:0]  ev_ok;
    logic [N_SRC-1:0]  grant_mask;
    logic [N_SRC-1:0]  drop;
    logic [N_SRC-1:0]  grant_inc;
    logic              grant;
    src_e              grant_src;
    state_e            state;
    logic [TO_W-1:0]   to_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            req_sync_d <= 1'b0;
        end else begin
            req_sync_d <= req_sync;
        end
    end

    always_ff @(posedge dac_clk) begin
        if (dac_rst || !cfg_en || (per_cnt == '0)) begin
            per_cnt <= cfg_per_min1;
        end else begin
            per_cnt <= per_cnt - PER_W'(1);
        end
    end

    // A re-arriving event on the source being granted re-arms it rather than
    // counting as a drop, because the grant mask is removed first.
    always_comb begin
        ev         = {per_cnt == '0, req_sw, req_sync & ~req_sync_d};
        ev_ok      = ev & cfg_src_en & {N_SRC{cfg_en}};
        grant      = (state == ST_IDLE) && cfg_en && (|pend);
        grant_src  = prio_pick(pend);
        grant_mask = grant ? src_onehot(grant_src) : '0;
        drop       = ev_ok & pend & ~grant_mask;
        for (int i = 0; i < N_SRC; i++) begin
            grant_inc[i] = (state == ST_ISSUE) && (tx_src == 2'(i));
        end
    end

    always_ff @(posedge dac_clk) begin
        if (dac_rst || !cfg_en) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~grant_mask) | ev_ok;
        end
    end

    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            state    <= ST_IDLE;
            tx_req   <= 1'b0;
            tx_src   <= SRC_SYNC;
            busy     <= 1'b0;
            err_to   <= 1'b0;
            to_cnt   <= '0;
            hold_cnt <= '0;
        end else begin
            tx_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state  <= ST_ISSUE;
                        tx_req <= 1'b1;
                        tx_src <= grant_src;
                        busy   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    to_cnt <= cfg_to_min1;
                    state  <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (txing) begin
                        state <= ST_ACTIVE;
                    end else if (to_cnt == '0) begin
                        err_to   <= 1'b1;
                        hold_cnt <= cfg_hold_min1;
                        state    <= ST_HOLD;
                    end else begin
                        to_cnt <= to_cnt - TO_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (!txing) begin
                        hold_cnt <= cfg_hold_min1;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Clearing the sticky flag takes precedence over a same-cycle timeout.
            if (clr_stats) begin
                err_to <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < N_SRC; i++) begin : g_stats
        sat_cnt #(.W(CNT_W)) u_grant (
            .clk (dac_clk),
            .rst (dac_rst),
            .clr (clr_stats),
            .inc (grant_inc[i]),
            .cnt (grant_cnt[i*CNT_W +: CNT_W])
        );
        sat_cnt #(.W(CNT_W)) u_drop (
            .clk (dac_clk),
            .rst (dac_rst),
            .clr (clr_stats),
            .inc (drop[i]),
            .cnt (drop_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_dac_tx_sched.sv
// Scoreboard bench for dac_tx_sched: directed scenarios push expected grants,
// a negedge monitor pops and compares them whenever tx_req is seen.
module tb_dac_tx_sched;

    localparam int PER_W  = 24;
    localparam int HOLD_W = 16;
    localparam int TO_W   = 8;
    localparam int CNT_W  = 2;

    localparam logic [1:0] EXP_SYNC = 2'd0;
    localparam logic [1:0] EXP_SW   = 2'd1;
    localparam logic [1:0] EXP_PER  = 2'd2;

    logic               dac_clk = 1'b0;
    logic               dac_rst;
    logic               cfg_en;
    logic [2:0]         cfg_src_en;
    logic [PER_W-1:0]   cfg_per_min1;
    logic [HOLD_W-1:0]  cfg_hold_min1;
    logic [TO_W-1:0]    cfg_to_min1;
    logic               req_sync;
    logic               req_sw;
    logic               txing;
    logic               clr_stats;
    logic               tx_req;
    logic [1:0]         tx_src;
    logic               busy;
    logic               err_to;
    logic [3*CNT_W-1:0] grant_cnt;
    logic [3*CNT_W-1:0] drop_cnt;

    typedef struct {
        int         cyc;
        logic [1:0] src;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0;

    dac_tx_sched #(
        .PER_W  (PER_W),
        .HOLD_W (HOLD_W),
        .TO_W   (TO_W),
        .CNT_W  (CNT_W)
    ) dut (
        .dac_clk       (dac_clk),
        .dac_rst       (dac_rst),
        .cfg_en        (cfg_en),
        .cfg_src_en    (cfg_src_en),
        .cfg_per_min1  (cfg_per_min1),
        .cfg_hold_min1 (cfg_hold_min1),
        .cfg_to_min1   (cfg_to_min1),
        .req_sync      (req_sync),
        .req_sw        (req_sw),
        .txing         (txing),
        .clr_stats     (clr_stats),
        .tx_req        (tx_req),
        .tx_src        (tx_src),
        .busy          (busy),
        .err_to        (err_to),
        .grant_cnt     (grant_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 dac_clk = ~dac_clk;

    always @(posedge dac_clk) cyc <= cyc + 1;

    // Monitor: every observed grant must match the head of the expectation queue.
    always @(negedge dac_clk) begin
        if (!dac_rst && tx_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL grant_unexpected: tx_req at cyc=%0d src=%0d, no grant expected", cyc, tx_src);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.src != tx_src) begin
                    failures++;
                    $display("[TB] FAIL grant: got cyc=%0d src=%0d expected cyc=%0d src=%0d",
                             cyc, tx_src, mon_e.cyc, mon_e.src);
                end
            end
        end
    end

    function automatic logic [CNT_W-1:0] gcnt(input int s);
        return grant_cnt[s*CNT_W +: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] dcnt(input int s);
        return drop_cnt[s*CNT_W +: CNT_W];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic sw, input logic sync, input logic clr);
        req_sw    = sw;
        req_sync  = sync;
        clr_stats = clr;
        @(negedge dac_clk);
        req_sw    = 1'b0;
        req_sync  = 1'b0;
        clr_stats = 1'b0;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge dac_clk);
    endtask

    task automatic pushGrant(input int c, input logic [1:0] s);
        exp_t e;
        e.cyc = c;
        e.src = s;
        exp_q.push_back(e);
    endtask

    initial begin
        dac_rst       = 1'b1;
        cfg_en        = 1'b1;
        cfg_src_en    = 3'b011;
        cfg_per_min1  = PER_W'(1000);
        cfg_hold_min1 = HOLD_W'(4);
        cfg_to_min1   = TO_W'(3);
        req_sync      = 1'b0;
        req_sw        = 1'b0;
        txing         = 1'b0;
        clr_stats     = 1'b0;
        repeat (3) @(negedge dac_clk);

        $display("[TB] reset values");
        checkOutput("rst_tx_req", tx_req, 0);
        checkOutput("rst_tx_src", tx_src, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err_to", err_to, 0);
        checkOutput("rst_grant_cnt", grant_cnt, 0);
        checkOutput("rst_drop_cnt", drop_cnt, 0);
        dac_rst = 1'b0;
        @(negedge dac_clk);

        $display("[TB] single sw request");
        t0 = cyc;
        pushGrant(t0 + 2, EXP_SW);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil(t0 + 4);
        txing = 1'b1;
        waitUntil(t0 + 5);
        checkOutput("t1_grant_sw", gcnt(1), 1);
        checkOutput("t1_busy_active", busy, 1);
        waitUntil(t0 + 14);
        txing = 1'b0;
        waitUntil(t0 + 19);
        checkOutput("t1_busy_hold_end", busy, 1);
        waitUntil(t0 + 20);
        checkOutput("t1_busy_idle", busy, 0);
        checkOutput("t1_tx_src_held", tx_src, EXP_SW);

        $display("[TB] priority sync over sw");
        t0 = cyc;
        pushGrant(t0 + 2, EXP_SYNC);
        pushGrant(t0 + 13, EXP_SW);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitUntil(t0 + 6);
        checkOutput("t2_err_to_before", err_to, 0);
        waitUntil(t0 + 8);
        checkOutput("t2_err_to_after", err_to, 1);
        waitUntil(t0 + 25);
        checkOutput("t2_grant_sync", gcnt(0), 1);
        checkOutput("t2_grant_sw", gcnt(1), 2);
        checkOutput("t2_tx_src", tx_src, EXP_SW);
        checkOutput("t2_busy", busy, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t2_clr_grant", grant_cnt, 0);
        checkOutput("t2_clr_err_to", err_to, 0);

        $display("[TB] drops during active");
        t0 = cyc;
        pushGrant(t0 + 2, EXP_SW);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil(t0 + 4);
        txing = 1'b1;
        waitUntil(t0 + 6);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil(t0 + 8);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil(t0 + 10);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil(t0 + 12);
        txing = 1'b0;
        pushGrant(t0 + 19, EXP_SW);
        waitUntil(t0 + 32);
        checkOutput("t3_drop_sw", dcnt(1), 2);
        checkOutput("t3_drop_sync", dcnt(0), 0);
        checkOutput("t3_grant_sw", gcnt(1), 2);
        checkOutput("t3_busy", busy, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] start timeout");
        cfg_to_min1 = TO_W'(7);
        t0 = cyc;
        pushGrant(t0 + 2, EXP_SW);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil(t0 + 10);
        checkOutput("t4_err_to_wait", err_to, 0);
        waitUntil(t0 + 11);
        checkOutput("t4_err_to_set", err_to, 1);
        waitUntil(t0 + 15);
        checkOutput("t4_busy_hold", busy, 1);
        waitUntil(t0 + 16);
        checkOutput("t4_busy_idle", busy, 0);
        waitUntil(t0 + 17);
        checkOutput("t4_err_to_sticky", err_to, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t4_err_to_clr", err_to, 0);
        checkOutput("t4_grant_clr", gcnt(1), 0);

        $display("[TB] periodic timer");
        cfg_en        = 1'b0;
        cfg_src_en    = 3'b100;
        cfg_per_min1  = PER_W'(99);
        cfg_to_min1   = TO_W'(0);
        cfg_hold_min1 = HOLD_W'(0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        t0 = cyc;
        cfg_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pushGrant(t0 + 101 + 100 * k, EXP_PER);
        end
        waitUntil(t0 + 510);
        checkOutput("t5_grant_per_sat", gcnt(2), 3);
        checkOutput("t5_drop_per", dcnt(2), 0);
        checkOutput("t5_tx_src", tx_src, EXP_PER);
        checkOutput("t5_err_to", err_to, 1);
        cfg_en = 1'b0;

        $display("[TB] disable during active");
        cfg_src_en    = 3'b011;
        cfg_to_min1   = TO_W'(3);
        cfg_hold_min1 = HOLD_W'(4);
        @(negedge dac_clk);
        cfg_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        t0 = cyc;
        pushGrant(t0 + 2, EXP_SW);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil(t0 + 4);
        txing = 1'b1;
        waitUntil(t0 + 6);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil(t0 + 8);
        cfg_en = 1'b0;
        waitUntil(t0 + 10);
        txing = 1'b0;
        checkOutput("t6_busy_not_aborted", busy, 1);
        waitUntil(t0 + 12);
        cfg_en = 1'b1;
        waitUntil(t0 + 15);
        checkOutput("t6_busy_hold", busy, 1);
        waitUntil(t0 + 16);
        checkOutput("t6_busy_idle", busy, 0);
        waitUntil(t0 + 30);
        checkOutput("t6_grant_sw", gcnt(1), 1);
        checkOutput("t6_drop_sw", dcnt(1), 0);

        $display("[TB] reset mid-burst");
        t0 = cyc;
        pushGrant(t0 + 2, EXP_SW);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil(t0 + 4);
        txing = 1'b1;
        waitUntil(t0 + 5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil(t0 + 7);
        checkOutput("t7_busy_pre", busy, 1);
        dac_rst = 1'b1;
        waitUntil(t0 + 8);
        checkOutput("t7_rst_busy", busy, 0);
        checkOutput("t7_rst_tx_req", tx_req, 0);
        checkOutput("t7_rst_tx_src", tx_src, 0);
        checkOutput("t7_rst_err_to", err_to, 0);
        checkOutput("t7_rst_grant_cnt", grant_cnt, 0);
        checkOutput("t7_rst_drop_cnt", drop_cnt, 0);
        dac_rst = 1'b0;
        txing   = 1'b0;
        waitUntil(t0 + 20);
        checkOutput("t7_busy_after", busy, 0);

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
